// File: rtl/fanin_rr_merge_pkg.sv
// Shared defaults and buffer entry layout for the round-robin fan-in merge.
package fanin_rr_merge_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int ID_W_DEF    = $clog2(NUM_SRC_DEF);
    localparam int BEAT_CNT_W  = 16;

    typedef struct packed {
        logic [ID_W_DEF-1:0]   src;
        logic [DATA_W_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/fanin_skid_fifo.sv
// Two-entry buffer between the arbiter and the merged output; flush drops all entries.
module fanin_skid_fifo
    import fanin_rr_merge_pkg::*;
#(
    parameter type entry_t = fifo_entry_t
) (
    input  logic   CLK,
    input  logic   ASYNCRESET,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t push_entry,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fanin_rr_merge.sv
// Round-robin merge of NUM_SRC valid/ready sources into one tagged stream,
// with a saturating count of delivered beats.
module fanin_rr_merge
    import fanin_rr_merge_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                           CLK,
    input  logic                           ASYNCRESET,
    input  logic [NUM_SRC-1:0]             cfg_en,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC-1:0][DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]             src_ready,
    output logic                           dst_valid,
    output logic [DATA_W-1:0]              dst_data,
    output logic [ID_W-1:0]                dst_src,
    input  logic                           dst_ready,
    output logic [BEAT_CNT_W-1:0]          beat_cnt
);

    typedef struct packed {
        logic [ID_W-1:0]   src;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [NUM_SRC-1:0]    eligible;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       rr_next;
    logic [ID_W-1:0]       winner;
    logic                  found;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    entry_t                push_entry;
    entry_t                head;
    logic [BEAT_CNT_W-1:0] beat_cnt_q;

    assign eligible = cfg_en & src_valid;

    // First eligible source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (found && !full && !flush && !ASYNCRESET) begin
            src_ready[winner] = 1'b1;
        end
    end

    assign push            = |(src_valid & src_ready);
    assign push_entry.src  = winner;
    assign push_entry.data = src_data[winner];
    assign rr_next         = (int'(winner) == NUM_SRC - 1) ? '0 : winner + ID_W'(1);

    // Flush wins over a simultaneous pop, so flushed beats are never counted.
    assign pop = dst_valid & dst_ready & ~flush;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            rr_ptr     <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (push) begin
                rr_ptr <= rr_next;
            end
            if (pop && beat_cnt_q != '1) begin
                beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
            end
        end
    end

    fanin_skid_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .full       (full),
        .empty      (empty),
        .head       (head)
    );

    assign dst_valid = ~empty;
    assign dst_data  = head.data;
    assign dst_src   = head.src;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_fanin_rr_merge.sv
// Directed bench for fanin_rr_merge: vector table for arbitration order plus
// hand sequences for backpressure, flush, async reset and count saturation.
module tb_fanin_rr_merge;

    logic              CLK = 1'b0;
    logic              ASYNCRESET;
    logic [3:0]        cfg_en;
    logic              flush;
    logic [3:0]        src_valid;
    logic [3:0][15:0]  src_data;
    logic [3:0]        src_ready;
    logic              dst_valid;
    logic [15:0]       dst_data;
    logic [1:0]        dst_src;
    logic              dst_ready;
    logic [15:0]       beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fanin_rr_merge dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .cfg_en     (cfg_en),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .dst_valid  (dst_valid),
        .dst_data   (dst_data),
        .dst_src    (dst_src),
        .dst_ready  (dst_ready),
        .beat_cnt   (beat_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  cfg;
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_dv;
        logic [1:0]  exp_src;
        logic [15:0] exp_beat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic default_data();
        for (int i = 0; i < 4; i++) begin
            src_data[i] = 16'hA000 + 16'(i);
        end
    endtask

    initial begin
        // cfg, valid, rdy, exp_ready, exp_dv, exp_src, exp_beat
        vecs[0]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 16'd0};
        vecs[1]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 16'd0};
        vecs[2]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 16'd1};
        vecs[3]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 16'd2};
        vecs[4]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 16'd3};
        vecs[5]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 16'd4};
        vecs[6]  = '{4'h5, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 16'd5};
        vecs[7]  = '{4'h5, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd2, 16'd6};
        vecs[8]  = '{4'h5, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd0, 16'd7};
        vecs[9]  = '{4'h5, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd2, 16'd8};
        vecs[10] = '{4'h5, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd0, 16'd9};
        vecs[11] = '{4'hF, 4'h0, 1'b1, 4'b0000, 1'b1, 2'd2, 16'd10};
        vecs[12] = '{4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 16'd11};

        ASYNCRESET = 1'b1;
        cfg_en     = 4'hF;
        flush      = 1'b0;
        src_valid  = 4'h0;
        dst_ready  = 1'b0;
        default_data();

        repeat (2) @(negedge CLK);
        src_valid = 4'hF;
        #1;
        check("reset src_ready", src_ready, 4'h0);
        check("reset dst_valid", dst_valid, 1'b0);
        check("reset dst_data", dst_data, 16'h0);
        check("reset dst_src", dst_src, 2'd0);
        check("reset beat_cnt", beat_cnt, 16'h0);
        src_valid = 4'h0;
        @(negedge CLK);
        ASYNCRESET = 1'b0;

        // Arbitration order, cfg_en masking and drain
        for (int v = 0; v < 13; v++) begin
            @(negedge CLK);
            cfg_en    = vecs[v].cfg;
            src_valid = vecs[v].valid;
            dst_ready = vecs[v].rdy;
            #1;
            check($sformatf("vec%0d src_ready", v), src_ready, vecs[v].exp_ready);
            check($sformatf("vec%0d dst_valid", v), dst_valid, vecs[v].exp_dv);
            check($sformatf("vec%0d beat_cnt", v), beat_cnt, vecs[v].exp_beat);
            if (vecs[v].exp_dv) begin
                check($sformatf("vec%0d dst_src", v), dst_src, vecs[v].exp_src);
                check($sformatf("vec%0d dst_data", v), dst_data, 16'hA000 + 16'(vecs[v].exp_src));
            end
        end

        // Backpressure: src 2 sends A1, A2, A3 with dst_ready low (rr_ptr=3)
        @(negedge CLK);
        cfg_en = 4'hF; src_valid = 4'b0100; dst_ready = 1'b0; src_data[2] = 16'h00A1;
        #1;
        check("bp first ready", src_ready, 4'b0100);
        check("bp first dv", dst_valid, 1'b0);
        @(negedge CLK);
        src_data[2] = 16'h00A2;
        #1;
        check("bp second ready", src_ready, 4'b0100);
        check("bp head A1", dst_data, 16'h00A1);
        @(negedge CLK);
        src_data[2] = 16'h00A3;
        #1;
        check("bp full ready", src_ready, 4'b0000);
        check("bp full src", dst_src, 2'd2);
        check("bp full data", dst_data, 16'h00A1);
        @(negedge CLK);
        #1;
        check("bp stall ready", src_ready, 4'b0000);
        check("bp stall data", dst_data, 16'h00A1);
        @(negedge CLK);
        dst_ready = 1'b1;
        #1;
        check("bp pop ready", src_ready, 4'b0000);
        check("bp out A1", dst_data, 16'h00A1);
        @(negedge CLK);
        #1;
        check("bp refill ready", src_ready, 4'b0100);
        check("bp out A2", dst_data, 16'h00A2);
        @(negedge CLK);
        src_valid = 4'h0;
        #1;
        check("bp out A3", dst_data, 16'h00A3);
        check("bp out A3 dv", dst_valid, 1'b1);
        @(negedge CLK);
        #1;
        check("bp empty dv", dst_valid, 1'b0);
        check("bp beat_cnt", beat_cnt, 16'd14);
        default_data();

        // Flush at count=2 with dst_ready high (rr_ptr=3)
        src_valid = 4'b0011; dst_ready = 1'b0;
        #1;
        check("fl fill0 ready", src_ready, 4'b0001);
        @(negedge CLK);
        #1;
        check("fl fill1 ready", src_ready, 4'b0010);
        @(negedge CLK);
        src_valid = 4'h0; flush = 1'b1; dst_ready = 1'b1;
        #1;
        check("fl full dv", dst_valid, 1'b1);
        check("fl flush ready", src_ready, 4'b0000);
        @(negedge CLK);
        flush = 1'b0;
        #1;
        check("fl after dv", dst_valid, 1'b0);
        check("fl after beat_cnt", beat_cnt, 16'd14);
        src_valid = 4'hF;
        #1;
        check("fl rr_ptr held", src_ready, 4'b0100);
        src_valid = 4'h0;

        // Async reset between edges with count=1 (rr_ptr=2 before this)
        @(negedge CLK);
        src_valid = 4'b0100; dst_ready = 1'b0;
        #1;
        check("rst pre ready", src_ready, 4'b0100);
        @(negedge CLK);
        src_valid = 4'b1010;
        #1;
        check("rst pre dv", dst_valid, 1'b1);
        check("rst pre src", dst_src, 2'd2);
        #1;
        ASYNCRESET = 1'b1;
        #1;
        check("rst mid dv", dst_valid, 1'b0);
        check("rst mid data", dst_data, 16'h0);
        check("rst mid src", dst_src, 2'd0);
        check("rst mid ready", src_ready, 4'b0000);
        check("rst mid beat_cnt", beat_cnt, 16'h0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        #1;
        check("rst post grant", src_ready, 4'b0010);
        src_valid = 4'h0;

        // Saturation of beat_cnt from FFFE
        @(negedge CLK);
        force dut.beat_cnt_q = 16'hFFFE;
        #1;
        release dut.beat_cnt_q;
        check("sat preset", beat_cnt, 16'hFFFE);
        src_valid = 4'b0001; dst_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("sat one pop", beat_cnt, 16'hFFFF);
        @(negedge CLK);
        src_valid = 4'h0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("sat hold", beat_cnt, 16'hFFFF);
        check("sat drained", dst_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
